// File: rtl/gate_pkg.sv
// Shared gate-level constants: 4-bit truth tables indexed by {a, b}.
package gate_pkg;

  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 multiplexer, the leaf cell of the truth-table tree.
module mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/tt_mux4.sv
// One-bit truth-table lookup: b selects within each half of tt, a selects the half.
module tt_mux4 (
  input  logic       a,
  input  logic       b,
  input  logic [3:0] tt,
  output logic       y
);

  logic lo;
  logic hi;

  mux2 u_lo (
    .d0  (tt[0]),
    .d1  (tt[1]),
    .sel (b),
    .y   (lo)
  );

  mux2 u_hi (
    .d0  (tt[2]),
    .d1  (tt[3]),
    .sel (b),
    .y   (hi)
  );

  mux2 u_out (
    .d0  (lo),
    .d1  (hi),
    .sel (a),
    .y   (y)
  );

endmodule

// File: rtl/mux_logic_pipe.sv
// Two-stage valid/ready logic unit: per-bit truth-table lookup in S1, optional
// XOR accumulation across a packet plus parity in S2.
module mux_logic_pipe
  import gate_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [3:0]   in_tt,
  input  logic         in_acc,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_par
);

  logic [W-1:0] f;

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_f_q, s1_f_d;
  logic         s1_acc_q, s1_acc_d;
  logic         s1_last_q, s1_last_d;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_y_q, out_y_d;
  logic         out_par_q, out_par_d;
  logic [W-1:0] acc_q, acc_d;

  logic         s1_ready;
  logic         s2_ready;
  logic         in_fire;
  logic         s2_load;
  logic [W-1:0] s2_y;

  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    tt_mux4 u_bit (
      .a  (in_a[i]),
      .b  (in_b[i]),
      .tt (in_tt),
      .y  (f[i])
    );
  end

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;
  assign in_fire  = in_valid && s1_ready;
  assign s2_load  = s1_valid_q && s2_ready;

  // Accumulating beats fold into the pre-load accumulator; plain beats bypass it.
  assign s2_y = s1_acc_q ? (acc_q ^ s1_f_q) : s1_f_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_f_d      = s1_f_q;
    s1_acc_d    = s1_acc_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_par_d   = out_par_q;
    acc_d       = acc_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_f_d     = f;
      s1_acc_d   = in_acc;
      s1_last_d  = in_last && in_acc;
    end else if (s2_ready) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      out_y_d     = s2_y;
      out_par_d   = ^s2_y;
      if (s1_acc_q) begin
        acc_d = s1_last_q ? '0 : s2_y;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_f_q      <= '0;
      s1_acc_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_par_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_f_q      <= s1_f_d;
      s1_acc_q    <= s1_acc_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_par_q   <= out_par_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_par   = out_par_q;

endmodule
